// File: rtl/avaliador_ativos_pkg.sv
// Shared definitions for the active-node evaluator:
// FSM encoding, node-entry layout and default widths.
package avaliador_ativos_pkg;

    localparam int ADDR_W_DEF    = 10;
    localparam int DIST_W_DEF    = 6;
    localparam int CUSTO_W_DEF   = 4;
    localparam int NUM_PORTS_DEF = 8;

    // One-hot FSM: bit positions and encoded values
    localparam int ST_N      = 5;
    localparam int S_IDLE    = 0;
    localparam int S_SELECT  = 1;
    localparam int S_COMPARE = 2;
    localparam int S_PUSH    = 3;
    localparam int S_DONE    = 4;

    typedef logic [ST_N-1:0] state_t;

    localparam state_t ST_IDLE    = state_t'(1 << S_IDLE);
    localparam state_t ST_SELECT  = state_t'(1 << S_SELECT);
    localparam state_t ST_COMPARE = state_t'(1 << S_COMPARE);
    localparam state_t ST_PUSH    = state_t'(1 << S_PUSH);
    localparam state_t ST_DONE    = state_t'(1 << S_DONE);

    // Node entry is {valido, distancia, anterior}
    function automatic int valido_pos(input int aw, input int dw);
        return aw + dw;
    endfunction

    function automatic int dist_lsb(input int aw);
        return aw;
    endfunction

    localparam int ANTERIOR_LSB = 0;

endpackage

// File: rtl/avaliador_ativos_if.sv
// Command bus between the write-ordering stage and the evaluator:
// candidate bundle plus the ready/busy status returned upstream.
interface avaliador_ativos_if
    import avaliador_ativos_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_W_DEF,
    parameter int DISTANCIA_WIDTH = DIST_W_DEF,
    parameter int CUSTO_WIDTH     = CUSTO_W_DEF,
    parameter int NUM_PORTS       = NUM_PORTS_DEF
);

    logic                                 oe_atualizar_in;
    logic [NUM_PORTS-1:0]                 oe_vizinho_valido_in;
    logic [ADDR_WIDTH*NUM_PORTS-1:0]      oe_endereco_in;
    logic [CUSTO_WIDTH*NUM_PORTS-1:0]     oe_menor_vizinho_in;
    logic [DISTANCIA_WIDTH*NUM_PORTS-1:0] oe_distancia_in;
    logic [ADDR_WIDTH-1:0]                oe_anterior_in;
    logic                                 aa_atualizar_ready_out;
    logic                                 aa_ocupado_out;

    modport master (
        output oe_atualizar_in,
        output oe_vizinho_valido_in,
        output oe_endereco_in,
        output oe_menor_vizinho_in,
        output oe_distancia_in,
        output oe_anterior_in,
        input  aa_atualizar_ready_out,
        input  aa_ocupado_out
    );

    modport slave (
        input  oe_atualizar_in,
        input  oe_vizinho_valido_in,
        input  oe_endereco_in,
        input  oe_menor_vizinho_in,
        input  oe_distancia_in,
        input  oe_anterior_in,
        output aa_atualizar_ready_out,
        output aa_ocupado_out
    );

endinterface

// File: rtl/avaliador_ativos_seletor_vizinho.sv
// Lowest-set-bit priority encoder over a candidate mask.
// Shared with the upstream ordering stage.
module seletor_vizinho #(
    parameter int NUM_PORTS = 8,
    parameter int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] mask,
    output logic [IDX_W-1:0]     idx,
    output logic                 any
);

    always_comb begin
        idx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
    end

    assign any = |mask;

endmodule

// File: rtl/avaliador_ativos.sv
// Relax stage: read-modify-write of the node table for each valid
// candidate, pushing improved nodes into the active list.
module avaliador_ativos
    import avaliador_ativos_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_W_DEF,
    parameter int DISTANCIA_WIDTH = DIST_W_DEF,
    parameter int CUSTO_WIDTH     = CUSTO_W_DEF,
    parameter int NUM_PORTS       = NUM_PORTS_DEF,
    localparam int ENTRY_W = 1 + DISTANCIA_WIDTH + ADDR_WIDTH,
    localparam int PRIO_W  = DISTANCIA_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    avaliador_ativos_if.slave     cmd,
    output logic                  mem_rd_en_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    input  logic [ENTRY_W-1:0]    mem_rd_data_in,
    output logic                  mem_wr_en_out,
    output logic [ENTRY_W-1:0]    mem_wr_data_out,
    output logic                  al_push_out,
    input  logic                  al_push_ready_in,
    output logic [ADDR_WIDTH-1:0] al_endereco_out,
    output logic [PRIO_W-1:0]     al_prioridade_out
);

    localparam int AW       = ADDR_WIDTH;
    localparam int DW       = DISTANCIA_WIDTH;
    localparam int CW       = CUSTO_WIDTH;
    localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int VAL_POS  = valido_pos(AW, DW);
    localparam int DIST_LSB = dist_lsb(AW);

    state_t state_q, state_d;

    logic [NUM_PORTS-1:0] pend_q, pend_nx;
    logic [IDX_W-1:0]     k_q, k_cur, k_nx;
    logic                 any_cur, any_nx;

    logic [AW-1:0] end_q [NUM_PORTS];
    logic [AW-1:0] end_nx [NUM_PORTS];
    logic [DW-1:0] dist_q [NUM_PORTS];
    logic [CW-1:0] cost_q [NUM_PORTS];
    logic [AW-1:0] ant_q;

    logic          cap;
    logic          improved;
    logic          rd_valido;
    logic [DW-1:0] rd_dist;
    logic          unused_rd;

    logic               rd_en_d, wr_en_d, push_d;
    logic               ready_d, ocupado_d;
    logic [AW-1:0]      addr_d, al_end_d;
    logic [ENTRY_W-1:0] wr_data_d;
    logic [PRIO_W-1:0]  prio_d;

    assign cap       = state_q[S_IDLE] && cmd.oe_atualizar_in;
    assign rd_valido = mem_rd_data_in[VAL_POS];
    assign rd_dist   = mem_rd_data_in[DIST_LSB +: DW];
    assign unused_rd = ^mem_rd_data_in[ANTERIOR_LSB +: AW];
    assign improved  = !rd_valido || (dist_q[k_q] < rd_dist);

    // k_cur picks the slot being read now; k_nx pre-selects the next one
    seletor_vizinho #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_sel_cur (
        .mask (pend_q),
        .idx  (k_cur),
        .any  (any_cur)
    );

    seletor_vizinho #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_sel_nx (
        .mask (pend_nx),
        .idx  (k_nx),
        .any  (any_nx)
    );

    always_comb begin
        pend_nx = pend_q;
        if (cap) begin
            pend_nx = cmd.oe_vizinho_valido_in;
        end else if (state_q[S_SELECT] && any_cur) begin
            pend_nx[k_cur] = 1'b0;
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            end_nx[i] = cap ? cmd.oe_endereco_in[AW*i +: AW] : end_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            k_q    <= '0;
            ant_q  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                end_q[i]  <= '0;
                dist_q[i] <= '0;
                cost_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_nx;
            if (state_q[S_SELECT] && any_cur) k_q <= k_cur;
            if (cap) begin
                ant_q <= cmd.oe_anterior_in;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    end_q[i]  <= end_nx[i];
                    dist_q[i] <= cmd.oe_distancia_in[DW*i +: DW];
                    cost_q[i] <= cmd.oe_menor_vizinho_in[CW*i +: CW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q[S_IDLE]: begin
                if (cmd.oe_atualizar_in) state_d = ST_SELECT;
            end
            state_q[S_SELECT]: begin
                state_d = any_cur ? ST_COMPARE : ST_DONE;
            end
            state_q[S_COMPARE]: begin
                state_d = improved ? ST_PUSH : ST_SELECT;
            end
            state_q[S_PUSH]: begin
                if (al_push_ready_in) state_d = ST_SELECT;
            end
            state_q[S_DONE]: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed for the upcoming state and registered below
    always_comb begin
        ocupado_d = !state_d[S_IDLE];
        ready_d   = state_d[S_DONE];
        rd_en_d   = state_d[S_SELECT] && any_nx;
        wr_en_d   = state_q[S_COMPARE] && improved;
        push_d    = state_d[S_PUSH];
        addr_d    = '0;
        wr_data_d = '0;
        al_end_d  = '0;
        prio_d    = '0;
        if (rd_en_d) begin
            addr_d = end_nx[k_nx];
        end else if (wr_en_d) begin
            addr_d = end_q[k_q];
        end
        if (wr_en_d) begin
            wr_data_d = {1'b1, dist_q[k_q], ant_q};
        end
        if (push_d) begin
            al_end_d = end_q[k_q];
            prio_d   = PRIO_W'(dist_q[k_q]) + PRIO_W'(cost_q[k_q]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd.aa_atualizar_ready_out <= 1'b0;
            cmd.aa_ocupado_out         <= 1'b0;
            mem_rd_en_out              <= 1'b0;
            mem_addr_out               <= '0;
            mem_wr_en_out              <= 1'b0;
            mem_wr_data_out            <= '0;
            al_push_out                <= 1'b0;
            al_endereco_out            <= '0;
            al_prioridade_out          <= '0;
        end else begin
            cmd.aa_atualizar_ready_out <= ready_d;
            cmd.aa_ocupado_out         <= ocupado_d;
            mem_rd_en_out              <= rd_en_d;
            mem_addr_out               <= addr_d;
            mem_wr_en_out              <= wr_en_d;
            mem_wr_data_out            <= wr_data_d;
            al_push_out                <= push_d;
            al_endereco_out            <= al_end_d;
            al_prioridade_out          <= prio_d;
        end
    end

endmodule

// File: tb/tb_avaliador_ativos.sv
// Self-checking bench for avaliador_ativos: directed cases plus
// random commands against a table-level reference model.
module tb_avaliador_ativos;

    localparam int AW = 10;
    localparam int DW = 6;
    localparam int CW = 4;
    localparam int NP = 8;
    localparam int EW = 1 + DW + AW;
    localparam int PW = DW + 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [EW-1:0] d;
    } we_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [PW-1:0] p;
    } pe_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    avaliador_ativos_if #(
        .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW),
        .CUSTO_WIDTH(CW), .NUM_PORTS(NP)
    ) cmd ();

    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [EW-1:0] rd_data, wr_data;
    logic          al_push, al_ready;
    logic [AW-1:0] al_end;
    logic [PW-1:0] al_prio;

    avaliador_ativos #(
        .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW),
        .CUSTO_WIDTH(CW), .NUM_PORTS(NP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmd               (cmd),
        .mem_rd_en_out     (mem_rd_en),
        .mem_addr_out      (mem_addr),
        .mem_rd_data_in    (rd_data),
        .mem_wr_en_out     (mem_wr_en),
        .mem_wr_data_out   (wr_data),
        .al_push_out       (al_push),
        .al_push_ready_in  (al_ready),
        .al_endereco_out   (al_end),
        .al_prioridade_out (al_prio)
    );

    logic [EW-1:0] tmem [1024];
    logic [EW-1:0] ref_mem [1024];
    we_t exp_wr[$];
    pe_t exp_push[$];
    pe_t push_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int stalls = 0;
    int wr_seen = 0;
    int bp_mode = 0;
    bit expect_ready = 0;
    bit prev_stall = 0;
    logic [AW-1:0] prev_a;
    logic [PW-1:0] prev_p;

    logic [NP-1:0] cv;
    logic [AW-1:0] ca [NP];
    logic [DW-1:0] cd [NP];
    logic [CW-1:0] cc [NP];
    logic [AW-1:0] cant;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endfunction

    always @(posedge clk) begin
        if (mem_wr_en) tmem[mem_addr] <= wr_data;
        if (mem_rd_en) rd_data <= tmem[mem_addr];
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        case (bp_mode)
            0:       al_ready = 1'b1;
            1:       al_ready = 1'($urandom_range(0, 1));
            default: al_ready = 1'b0;
        endcase
    end

    // Per-cycle monitor: writes and pushes against the model queues
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (mem_wr_en) begin
                we_t w;
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'(mem_addr), 32'hFFFF);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.a));
                    chk("wr_data", 32'(wr_data), 32'(w.d));
                end
            end
            if (al_push && al_ready) begin
                pe_t p;
                push_log.push_back('{a: al_end, p: al_prio});
                if (exp_push.size() == 0) begin
                    chk("unexpected_push", 32'(al_end), 32'hFFFF);
                end else begin
                    p = exp_push.pop_front();
                    chk("push_addr", 32'(al_end), 32'(p.a));
                    chk("push_prio", 32'(al_prio), 32'(p.p));
                end
            end
            if (prev_stall) begin
                chk("hold_push", 32'(al_push), 32'd1);
                chk("hold_addr", 32'(al_end), 32'(prev_a));
                chk("hold_prio", 32'(al_prio), 32'(prev_p));
            end
            if (al_push && !al_ready) stalls++;
            prev_stall = al_push && !al_ready;
            prev_a = al_end;
            prev_p = al_prio;
            if (!al_push) chk("al_idle", 32'({al_end, al_prio}), 32'd0);
            if (!mem_rd_en && !mem_wr_en) chk("addr_idle", 32'(mem_addr), 32'd0);
            if (!mem_wr_en) chk("wdata_idle", 32'(wr_data), 32'd0);
            if (cmd.aa_atualizar_ready_out && !expect_ready)
                chk("spurious_ready", 32'd1, 32'd0);
        end
    end

    task automatic clear_cmd();
        cv = '0;
        cant = '0;
        for (int i = 0; i < NP; i++) begin
            ca[i] = '0;
            cd[i] = '0;
            cc[i] = '0;
        end
    endtask

    task automatic set_entry(input int a, input logic [EW-1:0] e);
        tmem[a] = e;
        ref_mem[a] = e;
    endtask

    // Model applies the whole command to the reference table up front
    task automatic issue(output int t0, output int nv, output int np);
        logic [EW-1:0] cur;
        nv = 0;
        np = 0;
        for (int i = 0; i < NP; i++) begin
            if (cv[i]) begin
                nv++;
                cur = ref_mem[ca[i]];
                if (!cur[EW-1] || cd[i] < cur[AW +: DW]) begin
                    ref_mem[ca[i]] = {1'b1, cd[i], cant};
                    exp_wr.push_back('{a: ca[i], d: {1'b1, cd[i], cant}});
                    exp_push.push_back('{a: ca[i], p: PW'(cd[i]) + PW'(cc[i])});
                    np++;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            cmd.oe_endereco_in[AW*i +: AW]      = ca[i];
            cmd.oe_distancia_in[DW*i +: DW]     = cd[i];
            cmd.oe_menor_vizinho_in[CW*i +: CW] = cc[i];
        end
        cmd.oe_vizinho_valido_in = cv;
        cmd.oe_anterior_in = cant;
        cmd.oe_atualizar_in = 1'b1;
        stalls = 0;
        t0 = cyc;
        expect_ready = 1;
        @(negedge clk);
        chk("ocupado_at_strobe", 32'(cmd.aa_ocupado_out), 32'd0);
        @(posedge clk);
        #1;
        cmd.oe_atualizar_in = 1'b0;
        cmd.oe_vizinho_valido_in = '0;
    endtask

    task automatic wait_done(input int t0, input int nv, input int np, output int lat);
        bit seen = 0;
        lat = -1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (cmd.aa_atualizar_ready_out) begin
                seen = 1;
                break;
            end
            chk("ocupado_busy", 32'(cmd.aa_ocupado_out), 32'd1);
        end
        if (!seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            lat = cyc - t0;
            chk("latency", 32'(lat), 32'(2 + 2*nv + np + stalls));
            chk("ocupado_done", 32'(cmd.aa_ocupado_out), 32'd1);
            @(negedge clk);
            chk("ready_pulse", 32'(cmd.aa_atualizar_ready_out), 32'd0);
            chk("ocupado_idle", 32'(cmd.aa_ocupado_out), 32'd0);
        end
        expect_ready = 0;
        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("push_queue_empty", 32'(exp_push.size()), 32'd0);
    endtask

    task automatic run_cmd(output int lat);
        int t0, nv, np;
        issue(t0, nv, np);
        wait_done(t0, nv, np, lat);
    endtask

    initial begin
        int lat, t0, nv, np, w0;
        bit seen;
        for (int i = 0; i < 1024; i++) begin
            tmem[i] = '0;
            ref_mem[i] = '0;
        end
        rd_data = '0;
        al_ready = 1'b1;
        cmd.oe_atualizar_in = 1'b0;
        cmd.oe_vizinho_valido_in = '0;
        cmd.oe_endereco_in = '0;
        cmd.oe_distancia_in = '0;
        cmd.oe_menor_vizinho_in = '0;
        cmd.oe_anterior_in = '0;
        clear_cmd();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(cmd.aa_atualizar_ready_out), 32'd0);
        chk("rst_ocupado", 32'(cmd.aa_ocupado_out), 32'd0);
        chk("rst_mem", 32'({mem_rd_en, mem_wr_en, mem_addr}), 32'd0);
        chk("rst_al", 32'({al_push, al_end, al_prio}), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Two candidates into an empty table
        clear_cmd();
        cv = 8'b0000_0101;
        ca[0] = 3; cd[0] = 5; cc[0] = 2;
        ca[2] = 7; cd[2] = 9; cc[2] = 1;
        cant = 1;
        push_log.delete();
        run_cmd(lat);
        chk("t1_lat", 32'(lat), 32'd8);
        chk("t1_mem3", 32'(tmem[3]), 32'({1'b1, 6'd5, 10'd1}));
        chk("t1_mem7", 32'(tmem[7]), 32'({1'b1, 6'd9, 10'd1}));
        chk("t1_npush", 32'(push_log.size()), 32'd2);
        if (push_log.size() == 2) begin
            chk("t1_push0", 32'(push_log[0]), 32'({10'd3, 7'd7}));
            chk("t1_push1", 32'(push_log[1]), 32'({10'd7, 7'd10}));
        end

        // Equal distance is not an improvement; smaller is
        set_entry(3, {1'b1, 6'd4, 10'd9});
        clear_cmd();
        cv = 8'b0000_0001;
        ca[0] = 3; cd[0] = 4; cc[0] = 1; cant = 2;
        w0 = wr_seen;
        run_cmd(lat);
        chk("t2_eq_lat", 32'(lat), 32'd4);
        chk("t2_eq_nowrite", 32'(wr_seen - w0), 32'd0);
        cd[0] = 3;
        run_cmd(lat);
        chk("t2_lt_lat", 32'(lat), 32'd5);
        chk("t2_lt_mem", 32'(tmem[3]), 32'({1'b1, 6'd3, 10'd2}));

        // No valid candidates
        clear_cmd();
        w0 = wr_seen;
        run_cmd(lat);
        chk("t3_lat", 32'(lat), 32'd2);
        chk("t3_nowrite", 32'(wr_seen - w0), 32'd0);

        // Duplicate address within one command
        clear_cmd();
        cv = 8'b0000_0011;
        ca[0] = 5; cd[0] = 6; cc[0] = 3;
        ca[1] = 5; cd[1] = 2; cc[1] = 4;
        cant = 11;
        push_log.delete();
        run_cmd(lat);
        chk("t4_mem5", 32'(tmem[5]), 32'({1'b1, 6'd2, 10'd11}));
        chk("t4_npush", 32'(push_log.size()), 32'd2);
        if (push_log.size() == 2) begin
            chk("t4_push0", 32'(push_log[0]), 32'({10'd5, 7'd9}));
            chk("t4_push1", 32'(push_log[1]), 32'({10'd5, 7'd6}));
        end

        // Active list full for 10 cycles
        clear_cmd();
        cv = 8'b0000_0001;
        ca[0] = 30; cd[0] = 1; cc[0] = 3; cant = 4;
        bp_mode = 2;
        issue(t0, nv, np);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = al_push;
        end
        chk("t5_push_seen", 32'(seen), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t5_push", 32'(al_push), 32'd1);
            chk("t5_addr", 32'(al_end), 32'd30);
            chk("t5_prio", 32'(al_prio), 32'd4);
            chk("t5_busy", 32'(cmd.aa_ocupado_out), 32'd1);
            chk("t5_noready", 32'(cmd.aa_atualizar_ready_out), 32'd0);
        end
        bp_mode = 0;
        wait_done(t0, nv, np, lat);

        // Reset while stalled in PUSH
        clear_cmd();
        cv = 8'b0000_0001;
        ca[0] = 20; cd[0] = 3; cc[0] = 2; cant = 6;
        bp_mode = 2;
        issue(t0, nv, np);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            seen = al_push;
        end
        chk("t6_push_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_al", 32'({al_push, al_end, al_prio}), 32'd0);
        chk("t6_rst_mem", 32'({mem_rd_en, mem_wr_en, mem_addr, wr_data}), 32'd0);
        chk("t6_rst_stat", 32'({cmd.aa_atualizar_ready_out, cmd.aa_ocupado_out}), 32'd0);
        exp_push.delete();
        expect_ready = 0;
        chk("t6_wr_done", 32'(exp_wr.size()), 32'd0);
        chk("t6_mem20", 32'(tmem[20]), 32'({1'b1, 6'd3, 10'd6}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bp_mode = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t6_no_ready", 32'(cmd.aa_atualizar_ready_out), 32'd0);
        end
        cd[0] = 2;
        run_cmd(lat);
        chk("t6_after_lat", 32'(lat), 32'd5);
        chk("t6_after_mem", 32'(tmem[20]), 32'({1'b1, 6'd2, 10'd6}));

        // Random commands over a small address window
        for (int n = 0; n < 60; n++) begin
            bp_mode = (n % 2 == 1) ? 1 : 0;
            cv = NP'($urandom);
            cant = AW'($urandom);
            for (int i = 0; i < NP; i++) begin
                ca[i] = AW'($urandom_range(0, 15));
                cd[i] = DW'($urandom);
                cc[i] = CW'($urandom);
            end
            run_cmd(lat);
        end
        bp_mode = 0;
        for (int a = 0; a < 32; a++) begin
            chk("final_table", 32'(tmem[a]), 32'(ref_mem[a]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avaliador_ativos.md
Name: avaliador_ativos

Overview:
- Downstream consumer of the write-ordering stage.
- Accepts one update command per handshake; each command carries up to NUM_PORTS neighbour candidates.
- For each valid candidate it does a read-modify-write of the node table (relax step): store the new distance and predecessor if better, then push the node into the active list.
- Signals completion with a one-cycle ready pulse.
- Holds the ocupado (busy) flag so that upstream does not issue a new command while one is in progress.

Parameters:
- ADDR_WIDTH, 10, node address width.
- DISTANCIA_WIDTH, 6, accumulated distance width.
- CUSTO_WIDTH, 4, estimated cost (heuristic) width.
- NUM_PORTS, 8, candidates per command (equals upstream NUM_EA).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- oe_atualizar_in  in  1  command strobe, one cycle.
- oe_vizinho_valido_in  in  NUM_PORTS  per-candidate valid.
- oe_endereco_in  in  ADDR_WIDTH*NUM_PORTS  candidate node addresses; slot i at [ADDR_WIDTH*i +: ADDR_WIDTH].
- oe_menor_vizinho_in  in  CUSTO_WIDTH*NUM_PORTS  candidate estimated cost.
- oe_distancia_in  in  DISTANCIA_WIDTH*NUM_PORTS  candidate new distance.
- oe_anterior_in  in  ADDR_WIDTH  predecessor node, shared by all slots.
- aa_atualizar_ready_out  out  1  command complete, one-cycle pulse.
- aa_ocupado_out  out  1  busy.
- mem_rd_en_out  out  1  node-table read request.
- mem_addr_out  out  ADDR_WIDTH  read/write address.
- mem_rd_data_in  in  1+DISTANCIA_WIDTH+ADDR_WIDTH  {valido, distancia, anterior}; arrives one cycle after mem_rd_en_out.
- mem_wr_en_out  out  1  write strobe.
- mem_wr_data_out  out  1+DISTANCIA_WIDTH+ADDR_WIDTH  {1'b1, distancia, anterior}.
- al_push_out  out  1  active-list push; held until accepted.
- al_push_ready_in  in  1  active list accepts the push this cycle.
- al_endereco_out  out  ADDR_WIDTH  pushed node address.
- al_prioridade_out  out  DISTANCIA_WIDTH+1  distancia + menor_vizinho, zero-extended, no saturation.

Behaviour:
- Reset: every output 0, FSM in IDLE, captured registers cleared. Reset is allowed mid-command: the FSM aborts to IDLE with no write and no push, and no ready pulse follows.
- IDLE: aa_ocupado_out=0. On oe_atualizar_in=1:
  - capture all inputs into registers (pending mask = vizinho_valido);
  - go to SELECT; aa_ocupado_out=1 from the next cycle.
- SELECT:
  - pending mask == 0: go to DONE;
  - otherwise pick the lowest set index k, clear bit k, drive mem_addr_out=end[k] and mem_rd_en_out=1 for one cycle, go to COMPARE.
- COMPARE (read data valid this cycle): improvement = !rd.valido || dist[k] < rd.distancia.
  - Equal distance is not an improvement.
  - If improved: mem_wr_en_out=1 with address end[k] and data {1, dist[k], anterior}, go to PUSH.
  - If not improved: go to SELECT.
- PUSH:
  - al_push_out=1, al_endereco_out and al_prioridade_out held stable;
  - leave for SELECT in the cycle al_push_ready_in=1;
  - stall indefinitely while the active list is full.
- DONE:
  - aa_atualizar_ready_out=1 for exactly one cycle, then IDLE;
  - aa_ocupado_out stays 1 during DONE and drops in IDLE.
- Outputs: all FSM outputs are registered; mem and al outputs are 0 outside their states.
- Latency (no backpressure): command at cycle t, ready pulse at t+2+2V+P.
  - V = number of valid candidates; P = number of improvements.
  - Zero valid candidates: ready at t+2.
- Duplicate address in one command: sequential processing ensures the second read sees the first write (the write commits at least one cycle before the next read).
- oe_atualizar_in while not in IDLE: ignored; upstream guarantees this cannot occur.
- Priority sum: computed at DISTANCIA_WIDTH+1 bits, so it never wraps.

Decomposition:
- Shared header:
  - FSM state localparams (IDLE, SELECT, COMPARE, PUSH, DONE);
  - node-entry field offsets (valido MSB, distancia, anterior LSBs);
  - width defaults.
- Sub-module seletor_vizinho: combinational lowest-set-bit priority encoder.
  - Inputs: NUM_PORTS mask.
  - Outputs: index (clog2 width) and any flag.
  - Reused by the upstream ordering stage.

Test Plan:
- Empty table, command with valido=8'b0000_0101, end0=3, end2=7, dist0=5, dist2=9, cost 2/1, anterior=1 -> writes {1,5,1} to addr 3 and {1,9,1} to addr 7, pushes (3,7) then (7,10), one ready pulse.
- Addr 3 holds dist 4; candidate dist 4 -> no write, no push, ready pulse after 4 cycles. Candidate dist 3 -> write and push.
- valido=0 -> no memory access, ready pulse exactly 2 cycles after strobe, ocupado high 2 cycles.
- Same addr 5 in slots 0 (dist 6) and 1 (dist 2) -> two writes, final entry dist 2, two pushes in slot order.
- al_push_ready_in held low 10 cycles -> al_push_out and its data stable, ocupado stays 1, no ready until accept.
- Assert rst_n low during PUSH -> all outputs 0 immediately; after release no ready pulse; next command processes normally.
